// File: rtl/vga_pkg.sv
// vga_pkg: 800x600 @ 60 Hz timing constants (40 MHz pixel clock) and the
// coordinate type shared by the timing generator, draw stages and benches.
package vga_pkg;

  localparam int HOR_TOTAL_TIME  = 1056;
  localparam int HOR_BLANK_START = 800;
  localparam int HOR_SYNC_START  = 840;
  localparam int HOR_SYNC_STOP   = 968;
  localparam int VER_TOTAL_TIME  = 628;
  localparam int VER_BLANK_START = 600;
  localparam int VER_SYNC_START  = 601;
  localparam int VER_SYNC_STOP   = 605;

  typedef logic [10:0] coord_t;

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel coordinates, sync, blanking and frame markers from the
// timing generator (master) to downstream draw stages (slave).
interface vga_timing_if;
  import vga_pkg::*;

  coord_t      hcount;
  coord_t      vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: VGA raster generator. Two wrapping counters (pixel, line) with
// all decoded outputs registered from the next-state counts, so sync/blank
// and frame_start always describe the coordinate presented in the same cycle.
// Optional macro VGA_TIMING_FRAME_CNT_EN enables the completed-frame counter;
// without it frame_cnt is tied to 0.
module vga_timing #(
  parameter int HOR_TOTAL_TIME  = vga_pkg::HOR_TOTAL_TIME,
  parameter int HOR_BLANK_START = vga_pkg::HOR_BLANK_START,
  parameter int HOR_SYNC_START  = vga_pkg::HOR_SYNC_START,
  parameter int HOR_SYNC_STOP   = vga_pkg::HOR_SYNC_STOP,
  parameter int VER_TOTAL_TIME  = vga_pkg::VER_TOTAL_TIME,
  parameter int VER_BLANK_START = vga_pkg::VER_BLANK_START,
  parameter int VER_SYNC_START  = vga_pkg::VER_SYNC_START,
  parameter int VER_SYNC_STOP   = vga_pkg::VER_SYNC_STOP
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  vga_o
);
  import vga_pkg::*;

  // Timing must fit the 11-bit counters and keep blank < sync start < sync stop.
  localparam bit PARAMS_OK =
    (HOR_BLANK_START < HOR_SYNC_START) && (HOR_SYNC_START < HOR_SYNC_STOP) &&
    (HOR_SYNC_STOP <= HOR_TOTAL_TIME) && (HOR_TOTAL_TIME <= 2047) &&
    (VER_BLANK_START < VER_SYNC_START) && (VER_SYNC_START < VER_SYNC_STOP) &&
    (VER_SYNC_STOP <= VER_TOTAL_TIME) && (VER_TOTAL_TIME <= 2047);

  if (!PARAMS_OK) begin : g_bad_timing
    $error("vga_timing: inconsistent timing parameters");
  end

  localparam coord_t H_LAST  = coord_t'(HOR_TOTAL_TIME - 1);
  localparam coord_t V_LAST  = coord_t'(VER_TOTAL_TIME - 1);
  localparam coord_t H_BLANK = coord_t'(HOR_BLANK_START);
  localparam coord_t H_SYNC0 = coord_t'(HOR_SYNC_START);
  localparam coord_t H_SYNC1 = coord_t'(HOR_SYNC_STOP);
  localparam coord_t V_BLANK = coord_t'(VER_BLANK_START);
  localparam coord_t V_SYNC0 = coord_t'(VER_SYNC_START);
  localparam coord_t V_SYNC1 = coord_t'(VER_SYNC_STOP);

  coord_t hcount_q, hcount_d;
  coord_t vcount_q, vcount_d;
  logic   hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic   frame_start_q, frame_start_d;

  // Next raster position: pixel wraps every line, line steps only at end of line.
  always_comb begin
    hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + coord_t'(1);
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + coord_t'(1);
    end
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
  end

  // Counters and decode registered together; reset lands on visible pixel (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblnk_q       <= (hcount_d >= H_BLANK);
      hsync_q       <= (hcount_d >= H_SYNC0) && (hcount_d < H_SYNC1);
      vblnk_q       <= (vcount_d >= V_BLANK);
      vsync_q       <= (vcount_d >= V_SYNC0) && (vcount_d < V_SYNC1);
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count each wrap to (0,0); the reset frame itself is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga_o.frame_cnt = frame_cnt_q;
`else
  assign vga_o.frame_cnt = '0;
`endif

  assign vga_o.hcount      = hcount_q;
  assign vga_o.vcount      = vcount_q;
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.hblnk       = hblnk_q;
  assign vga_o.vblnk       = vblnk_q;
  assign vga_o.frame_start = frame_start_q;

endmodule
